// File: rtl/pwm_hbridge.sv
// PWM generator for an H-bridge: edge/center-aligned modulator with cycle-by-cycle
// current limiting, a deadtime inserter and run/brake/enable output gating.
module pwm_hbridge #(
   parameter int WIDTH   = 8,
   parameter int DTWIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pwmcntce,
   input  logic               pwmldce,
   input  logic [WIDTH-1:0]   wrtdata,
   input  logic               dtldce,
   input  logic [DTWIDTH-1:0] dtdata,
   input  logic               centermode,
   input  logic               invertpwm,
   input  logic               enablepwm,
   input  logic               run,
   input  logic               currentlimit,
   output logic [1:0]         pwmout,
   output logic               periodstart,
   output logic               climited
);

   localparam logic [WIDTH-1:0]   CNT_MAX  = '1;
   localparam logic [WIDTH-1:0]   DUTY_RST = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [DTWIDTH-1:0] DT_RST   = DTWIDTH'(4);

   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic [WIDTH-1:0]   sync_q, sync_d;
   logic [DTWIDTH-1:0] dt_q, dt_d;
   logic               mode_q, mode_d;
   logic               raw_q, raw_d;
   logic               clim_q, clim_d;
   logic               ps_q, ps_d;
   logic [DTWIDTH-1:0] dtcnt_q, dtcnt_d;
   logic               last_q, last_d;
   logic               pstart;
   logic               pwmin;
   logic [1:0]         stage;

   // dir_q = 1 means the center-aligned counter is counting down
   assign pstart = pwmcntce && (mode_q ? ((cnt_q == '0) && dir_q) : (cnt_q == CNT_MAX));
   assign pwmin  = raw_q ^ invertpwm;

   always_comb begin
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
      sync_d  = sync_q;
      dt_d    = dt_q;
      mode_d  = mode_q;
      raw_d   = raw_q;
      clim_d  = clim_q;
      ps_d    = 1'b0;
      dtcnt_d = dtcnt_q;
      last_d  = last_q;

      if (pwmldce) hold_d = wrtdata;
      if (dtldce)  dt_d   = dtdata;

      // A period start always resumes counting upward, whichever mode comes next
      if (pwmcntce) begin
         if (pstart) begin
            cnt_d = {{(WIDTH-1){1'b0}}, mode_q};
            dir_d = 1'b0;
         end else if (!mode_q) begin
            cnt_d = cnt_q + 1'b1;
            dir_d = 1'b0;
         end else if (!dir_q) begin
            if (cnt_q == CNT_MAX) begin
               cnt_d = CNT_MAX - 1'b1;
               dir_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      if (pstart) begin
         sync_d = hold_q;
         mode_d = centermode;
         clim_d = 1'b0;
         ps_d   = 1'b1;
      end

      if (pwmcntce) begin
         if (pstart)         raw_d = centermode ? (cnt_q < hold_q) : 1'b1;
         else if (clim_q)    raw_d = 1'b0;
         else if (mode_q)    raw_d = (cnt_q < sync_q);
         else if (cnt_q == sync_q) raw_d = 1'b0;
      end

      // Overcurrent wins over everything, including a coincident period start
      if (currentlimit) begin
         raw_d  = 1'b0;
         clim_d = 1'b1;
      end

      if (dtcnt_q != '0) begin
         dtcnt_d = dtcnt_q - 1'b1;
      end else if (pwmin != last_q) begin
         last_d  = pwmin;
         dtcnt_d = dt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         hold_q  <= DUTY_RST;
         sync_q  <= '0;
         dt_q    <= DT_RST;
         mode_q  <= 1'b0;
         raw_q   <= 1'b0;
         clim_q  <= 1'b0;
         ps_q    <= 1'b0;
         dtcnt_q <= '0;
         last_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         hold_q  <= hold_d;
         sync_q  <= sync_d;
         dt_q    <= dt_d;
         mode_q  <= mode_d;
         raw_q   <= raw_d;
         clim_q  <= clim_d;
         ps_q    <= ps_d;
         dtcnt_q <= dtcnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      if (reset)                stage = 2'b10;
      else if (dtcnt_q != '0)   stage = 2'b00;
      else                      stage = {~last_q, last_q};

      if (!run)             pwmout = 2'b11;
      else if (!enablepwm)  pwmout = 2'b00;
      else                  pwmout = stage;
   end

   assign periodstart = ps_q;
   assign climited    = clim_q;

endmodule
